// File: rtl/nt_pkg.sv
// nt_pkg
// Shared definitions for the neurotransmitter level bank: default parameter
// values, the named channel indices, and the per-channel update action.
// No ports; this file is imported by nt_tick_divider and nt_level_bank.
package nt_pkg;

  localparam int NT_N_CH         = 5;
  localparam int NT_W            = 7;
  localparam int NT_HB_BASE      = 2;
  localparam int NT_STEP         = 4;
  localparam int NT_BASELINE     = 32;
  localparam int NT_DECAY_PERIOD = 4;

  // Channel positions inside the packed level vector.
  typedef enum int {
    CORTISOL       = 0,
    DOPAMINE       = 1,
    GABA           = 2,
    NOREPINEPHRINE = 3,
    SEROTONIN      = 4
  } nt_ch_e;

  // What a channel does on a model tick.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_INC   = 2'd1,
    ACT_DEC   = 2'd2,
    ACT_DECAY = 2'd3
  } nt_act_e;

endpackage

// File: rtl/nt_tick_divider.sv
// nt_tick_divider
// Produces a one-cycle enable pulse every 2^(HB_BASE+heartbeat) clocks.
// Ports:
//   clk       - single clock
//   rst_n     - synchronous active-low reset
//   heartbeat - tick rate select (0 = fastest)
//   tick      - one-cycle enable pulse on the last count of each period
module nt_tick_divider
  import nt_pkg::*;
#(
  parameter int HB_BASE = NT_HB_BASE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] heartbeat,
  output logic       tick
);

  localparam int CW = HB_BASE + 3;

  logic [CW-1:0] r_count;
  logic [1:0]    r_hbPrev;
  logic [CW-1:0] w_lastCount;
  logic          w_hbChange;
  logic          w_atLast;

  // The last count of a period is 2^(HB_BASE+heartbeat)-1, built as a mask
  // of ones. A heartbeat that differs from last cycle's value suppresses
  // the tick so the new rate always starts from a clean count of zero.
  always_comb begin
    w_lastCount = ~({CW{1'b1}} << (HB_BASE + int'(heartbeat)));
    w_hbChange  = (heartbeat != r_hbPrev);
    w_atLast    = (r_count == w_lastCount);
    tick        = rst_n && !w_hbChange && w_atLast;
  end

  // Heartbeat is captured even during reset so that releasing reset is not
  // mistaken for a rate change, keeping the first tick one full period out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_hbPrev <= heartbeat;
    end else begin
      r_hbPrev <= heartbeat;
      if (w_hbChange || w_atLast) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nt_level_bank.sv
// nt_level_bank
// Bank of N_CH saturating levels nudged by inc/dec requests on each model
// tick, slowly decaying toward BASELINE, with a direct-write load port.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   heartbeat             - tick rate select
//   inc, dec              - per-channel step requests, accumulated between ticks
//   freeze                - holds all levels and the decay counter
//   load_valid/ch/val     - direct write request; load_ready accepts it
//   load_err              - accepted load aimed at a channel that does not exist
//   tick                  - model tick pulse
//   level, level_q, sat   - packed levels, top two bits of each, saturation flags
module nt_level_bank
  import nt_pkg::*;
#(
  parameter int N_CH         = NT_N_CH,
  parameter int W            = NT_W,
  parameter int HB_BASE      = NT_HB_BASE,
  parameter int STEP         = NT_STEP,
  parameter int BASELINE     = NT_BASELINE,
  parameter int DECAY_PERIOD = NT_DECAY_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        heartbeat,
  input  logic [N_CH-1:0]   inc,
  input  logic [N_CH-1:0]   dec,
  input  logic              freeze,
  input  logic              load_valid,
  input  logic [3:0]        load_ch,
  input  logic [W-1:0]      load_val,
  output logic              load_ready,
  output logic              load_err,
  output logic              tick,
  output logic [N_CH*W-1:0] level,
  output logic [2*N_CH-1:0] level_q,
  output logic [N_CH-1:0]   sat
);

  localparam int             DCW        = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [W:0]     STEP_X     = (W+1)'(STEP);
  localparam logic [W:0]     MAX_X      = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0]   BASE_L     = W'(BASELINE);
  localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY_PERIOD - 1);

  logic [W-1:0]    r_level [N_CH];
  logic [N_CH-1:0] r_pendInc;
  logic [N_CH-1:0] r_pendDec;
  logic [DCW-1:0]  r_decayCnt;

  logic            w_tick;
  logic            w_loadFire;
  logic            w_loadInRange;
  logic            w_decayWrap;
  logic [N_CH-1:0] w_incAll;
  logic [N_CH-1:0] w_decAll;
  nt_act_e         w_act       [N_CH];
  logic [W:0]      w_sumUp     [N_CH];
  logic [W:0]      w_diffDn    [N_CH];
  logic [W-1:0]    w_levelNext [N_CH];

  nt_tick_divider #(
    .HB_BASE (HB_BASE)
  ) u_tickDivider (
    .clk       (clk),
    .rst_n     (rst_n),
    .heartbeat (heartbeat),
    .tick      (w_tick)
  );

  // Loads are refused during the tick cycle so a write never collides with
  // a model update. The current cycle's requests are folded into the pending
  // view so that a request arriving in the tick cycle still counts.
  always_comb begin
    tick          = w_tick;
    load_ready    = rst_n && !w_tick;
    w_loadFire    = load_valid && load_ready;
    w_loadInRange = (int'(load_ch) < N_CH);
    load_err      = w_loadFire && !w_loadInRange;
    w_incAll      = r_pendInc | inc;
    w_decAll      = r_pendDec | dec;
    w_decayWrap   = (r_decayCnt == DECAY_LAST);
  end

  // Classify each channel for the coming tick. Conflicting requests cancel,
  // and only channels with no request at all are eligible for decay.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_act[i] = ACT_HOLD;
      if (w_incAll[i] && !w_decAll[i]) begin
        w_act[i] = ACT_INC;
      end else if (w_decAll[i] && !w_incAll[i]) begin
        w_act[i] = ACT_DEC;
      end else if (!w_incAll[i] && !w_decAll[i] && w_decayWrap) begin
        w_act[i] = ACT_DECAY;
      end
    end
  end

  // Next level per channel. Steps are computed one bit wider than the level
  // so overflow and borrow are visible and can be clamped instead of
  // wrapping. A load can only fire outside the tick cycle, so it never
  // competes with a tick update.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_sumUp[i]     = {1'b0, r_level[i]} + STEP_X;
      w_diffDn[i]    = {1'b0, r_level[i]} - STEP_X;
      w_levelNext[i] = r_level[i];
      if (w_tick && !freeze) begin
        case (w_act[i])
          ACT_INC: begin
            w_levelNext[i] = (w_sumUp[i] > MAX_X) ? {W{1'b1}} : w_sumUp[i][W-1:0];
          end
          ACT_DEC: begin
            w_levelNext[i] = w_diffDn[i][W] ? '0 : w_diffDn[i][W-1:0];
          end
          ACT_DECAY: begin
            if (r_level[i] < BASE_L) begin
              w_levelNext[i] = r_level[i] + 1'b1;
            end else if (r_level[i] > BASE_L) begin
              w_levelNext[i] = r_level[i] - 1'b1;
            end
          end
          default: begin
            w_levelNext[i] = r_level[i];
          end
        endcase
      end
      if (w_loadFire && w_loadInRange && (int'(load_ch) == i)) begin
        w_levelNext[i] = load_val;
      end
    end
  end

  // State registers. Pending requests clear on every tick even while frozen,
  // but the decay counter only advances on ticks that actually update levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pendInc  <= '0;
      r_pendDec  <= '0;
      r_decayCnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_level[i] <= BASE_L;
      end
    end else begin
      if (w_tick) begin
        r_pendInc <= '0;
        r_pendDec <= '0;
        if (!freeze) begin
          r_decayCnt <= w_decayWrap ? '0 : r_decayCnt + 1'b1;
        end
      end else begin
        r_pendInc <= w_incAll;
        r_pendDec <= w_decAll;
      end
      for (int i = 0; i < N_CH; i++) begin
        r_level[i] <= w_levelNext[i];
      end
    end
  end

  // Outputs are pure functions of the level registers.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      level[i*W +: W]   = r_level[i];
      level_q[2*i +: 2] = r_level[i][W-1 -: 2];
      sat[i]            = (r_level[i] == '0) || (r_level[i] == '1);
    end
  end

endmodule

// File: tb/tb_nt_level_bank.sv
// tb_nt_level_bank
// Scoreboard bench for nt_level_bank: each driven cycle pushes the expected
// outputs from a behavioural model; a monitor pops and compares them.
module tb_nt_level_bank;
  import nt_pkg::*;

  localparam int N    = NT_N_CH;
  localparam int W    = NT_W;
  localparam int HB   = NT_HB_BASE;
  localparam int STEP = NT_STEP;
  localparam int BASE = NT_BASELINE;
  localparam int DP   = NT_DECAY_PERIOD;
  localparam int MAXL = (1 << W) - 1;

  logic           clk;
  logic           rst_n;
  logic [1:0]     heartbeat;
  logic [N-1:0]   inc;
  logic [N-1:0]   dec;
  logic           freeze;
  logic           load_valid;
  logic [3:0]     load_ch;
  logic [W-1:0]   load_val;
  logic           load_ready;
  logic           load_err;
  logic           tick;
  logic [N*W-1:0] level;
  logic [2*N-1:0] level_q;
  logic [N-1:0]   sat;

  nt_level_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .heartbeat  (heartbeat),
    .inc        (inc),
    .dec        (dec),
    .freeze     (freeze),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_val   (load_val),
    .load_ready (load_ready),
    .load_err   (load_err),
    .tick       (tick),
    .level      (level),
    .level_q    (level_q),
    .sat        (sat)
  );

  typedef struct packed {
    logic           tick;
    logic           ready;
    logic           err;
    logic [N*W-1:0] level;
    logic [2*N-1:0] q;
    logic [N-1:0]   sat;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   assertCount = 0;
  int   failCount   = 0;

  bit           sRst;
  bit [1:0]     sHb;
  bit [N-1:0]   sInc;
  bit [N-1:0]   sDec;
  bit           sFrz;
  bit           sLv;
  bit [3:0]     sLch;
  bit [W-1:0]   sLval;

  int       mLvl   [N];
  bit       mPendI [N];
  bit       mPendD [N];
  int       mPhase;
  int       mUnfrozen;
  bit [1:0] mPrevHb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counters stay in one place.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model state right after a reset edge.
  function automatic void modelReset(input bit [1:0] hb);
    for (int c = 0; c < N; c++) begin
      mLvl[c]   = BASE;
      mPendI[c] = 1'b0;
      mPendD[c] = 1'b0;
    end
    mPhase    = 0;
    mUnfrozen = 0;
    mPrevHb   = hb;
  endfunction

  // Whether the model expects a tick in the cycle about to be driven.
  function automatic bit modelTickNow();
    int period;
    period = 1 << (HB + int'(sHb));
    return sRst && (sHb == mPrevHb) && ((mPhase % period) == period - 1);
  endfunction

  // Drive one cycle, push its expected outputs, then advance the model
  // across the clock edge that ends the cycle.
  task automatic applyStimulus(output bit accepted);
    exp_t e;
    bit   t;
    bit   decayNow;
    @(posedge clk);
    #1;
    rst_n      = sRst;
    heartbeat  = sHb;
    inc        = sInc;
    dec        = sDec;
    freeze     = sFrz;
    load_valid = sLv;
    load_ch    = sLch;
    load_val   = sLval;
    for (int c = 0; c < N; c++) begin
      e.level[c*W +: W] = W'(mLvl[c]);
      e.q[2*c +: 2]     = 2'(mLvl[c] >> (W - 2));
      e.sat[c]          = (mLvl[c] == 0) || (mLvl[c] == MAXL);
    end
    t        = modelTickNow();
    accepted = sRst && sLv && !t;
    e.tick   = t;
    e.ready  = sRst && !t;
    e.err    = accepted && (int'(sLch) >= N);
    expQ.push_back(e);
    if (!sRst) begin
      modelReset(sHb);
    end else begin
      mPhase = (sHb != mPrevHb) ? 0 : mPhase + 1;
      for (int c = 0; c < N; c++) begin
        mPendI[c] = mPendI[c] | sInc[c];
        mPendD[c] = mPendD[c] | sDec[c];
      end
      if (t) begin
        if (!sFrz) begin
          mUnfrozen++;
          decayNow = ((mUnfrozen % DP) == 0);
          for (int c = 0; c < N; c++) begin
            if (mPendI[c] && !mPendD[c]) begin
              mLvl[c] = (mLvl[c] + STEP > MAXL) ? MAXL : mLvl[c] + STEP;
            end else if (mPendD[c] && !mPendI[c]) begin
              mLvl[c] = (mLvl[c] - STEP < 0) ? 0 : mLvl[c] - STEP;
            end else if (!mPendI[c] && !mPendD[c] && decayNow) begin
              if (mLvl[c] < BASE) mLvl[c] = mLvl[c] + 1;
              else if (mLvl[c] > BASE) mLvl[c] = mLvl[c] - 1;
            end
          end
        end
        for (int c = 0; c < N; c++) begin
          mPendI[c] = 1'b0;
          mPendD[c] = 1'b0;
        end
      end
      if (accepted && (int'(sLch) < N)) begin
        mLvl[sLch] = int'(sLval);
      end
      mPrevHb = sHb;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    sInc = '0;
    sDec = '0;
    sLv  = 1'b0;
    repeat (n) applyStimulus(acc);
  endtask

  task automatic pulse(input bit [N-1:0] incMask, input bit [N-1:0] decMask);
    bit acc;
    sInc = incMask;
    sDec = decMask;
    sLv  = 1'b0;
    applyStimulus(acc);
    sInc = '0;
    sDec = '0;
  endtask

  task automatic doLoad(input int ch, input int val);
    bit acc;
    sInc  = '0;
    sDec  = '0;
    sLv   = 1'b1;
    sLch  = 4'(ch);
    sLval = W'(val);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(acc);
      if (acc) break;
    end
    sLv = 1'b0;
  endtask

  task automatic checkLevel(input string name, input int ch, input int expv);
    checkOutput(name, 64'(level[ch*W +: W]), 64'(expv));
  endtask

  // After a reset release with heartbeat 0, ticks land on cycles 3, 7, 11.
  task automatic tickTimingCheck(input string name);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      @(negedge clk);
      checkOutput($sformatf("%s_cyc%0d", name, k), 64'(tick), 64'((k % 4) == 3));
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest
  // expectation, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monE = expQ.pop_front();
      checkOutput("tick",       64'(tick),       64'(monE.tick));
      checkOutput("load_ready", 64'(load_ready), 64'(monE.ready));
      checkOutput("load_err",   64'(load_err),   64'(monE.err));
      checkOutput("level",      64'(level),      64'(monE.level));
      checkOutput("level_q",    64'(level_q),    64'(monE.q));
      checkOutput("sat",        64'(sat),        64'(monE.sat));
    end
  end

  initial begin
    bit acc;
    rst_n = 1'b0; heartbeat = '0; inc = '0; dec = '0; freeze = 1'b0;
    load_valid = 1'b0; load_ch = '0; load_val = '0;
    sRst = 1'b0; sHb = '0; sInc = '0; sDec = '0; sFrz = 1'b0;
    sLv = 1'b0; sLch = '0; sLval = '0;
    modelReset(2'd0);
    repeat (2) @(posedge clk);
    $display("[TB] reset and tick timing");
    idle(2);
    sRst = 1'b1;
    tickTimingCheck("tick_release");

    $display("[TB] increment, decrement to floor");
    idle(1);
    pulse(N'(1) << DOPAMINE, '0);
    idle(4);
    @(negedge clk);
    checkLevel("ch1_after_inc", DOPAMINE, 36);
    for (int p = 0; p < 9; p++) begin
      pulse('0, N'(1) << DOPAMINE);
      idle(3);
    end
    @(negedge clk);
    checkLevel("ch1_floor", DOPAMINE, 0);
    checkOutput("sat1_floor", 64'(sat[DOPAMINE]), 64'(1));
    pulse('0, N'(1) << DOPAMINE);
    idle(3);

    $display("[TB] load and decay");
    doLoad(GABA, 100);
    idle(1);
    @(negedge clk);
    checkLevel("ch2_loaded", GABA, 100);
    idle(40);

    $display("[TB] conflicting requests and freeze");
    pulse(N'(1) << CORTISOL, N'(1) << CORTISOL);
    idle(4);
    sFrz = 1'b1;
    sInc = N'(1) << CORTISOL;
    repeat (12) applyStimulus(acc);
    @(negedge clk);
    checkLevel("ch0_frozen", CORTISOL, 32);
    sFrz = 1'b0;
    idle(8);

    $display("[TB] upper saturation");
    doLoad(SEROTONIN, 126);
    pulse(N'(1) << SEROTONIN, '0);
    idle(4);
    @(negedge clk);
    checkLevel("ch4_ceiling", SEROTONIN, 127);
    checkOutput("sat4_ceiling", 64'(sat[SEROTONIN]), 64'(1));

    $display("[TB] load stall on tick and bad channel");
    for (int k = 0; k < 40; k++) begin
      if (modelTickNow()) break;
      idle(1);
    end
    sLv = 1'b1; sLch = 4'(NOREPINEPHRINE); sLval = W'(80);
    applyStimulus(acc);
    @(negedge clk);
    checkOutput("stall_tick", 64'(tick), 64'(1));
    checkOutput("stall_ready", 64'(load_ready), 64'(0));
    applyStimulus(acc);
    @(negedge clk);
    checkOutput("ready_after_stall", 64'(load_ready), 64'(1));
    sLch = 4'd7; sLval = W'(5);
    applyStimulus(acc);
    @(negedge clk);
    checkOutput("load_err_ch7", 64'(load_err), 64'(1));
    sLv = 1'b0;
    idle(1);
    @(negedge clk);
    checkLevel("ch3_loaded", NOREPINEPHRINE, 80);

    $display("[TB] mid-period reset");
    idle(2);
    sRst = 1'b0;
    idle(1);
    sRst = 1'b1;
    tickTimingCheck("tick_rereset");
    for (int c = 0; c < N; c++) checkLevel($sformatf("ch%0d_after_reset", c), c, 32);

    $display("[TB] slow heartbeat");
    sHb = 2'd3;
    idle(70);
    sHb = 2'd0;
    idle(10);

    $display("[TB] random traffic");
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 59) == 0) sHb = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) sFrz = !sFrz;
      sRst = ($urandom_range(0, 399) != 0);
      for (int c = 0; c < N; c++) begin
        sInc[c] = ($urandom_range(0, 9) == 0);
        sDec[c] = ($urandom_range(0, 11) == 0);
      end
      sLv   = ($urandom_range(0, 9) == 0);
      sLch  = 4'($urandom_range(0, 7));
      sLval = W'($urandom);
      applyStimulus(acc);
    end
    sRst = 1'b1;
    idle(2);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
